muldiv_unit: RTL and testbench

Multiply/divide unit of the five-stage MIPS pipeline, located in the EX stage next to the ALU. It accepts mult, multu, div, divu, mthi and mtlo from EX and holds the architectural HI/LO registers. Its `busy` output goes to the hazard unit, which stalls later multiply/divide/move-from/move-to instructions in D. HI/LO contents feed the EX-stage mfhi/mflo result path.

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: result latched at issue, committed after MULT_CYCLES or DIV_CYCLES busy cycles; mthi/mtlo take one cycle.
// No backpressure: starts arriving while busy are dropped, and the hazard unit uses busy to stall issue.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, dvd, dvs;
    logic [31:0] quot_u, rem_u, quot, rem;

    // Signed division runs on magnitudes, then the signs are restored;
    // this also yields 0x80000000 for 0x80000000 / -1 without a special case.
    always_comb begin
        prod_s     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u     = {32'b0, a} * {32'b0, b};
        div_signed = (mdop == 3'd2);
        a_mag      = a[31] ? (32'd0 - a) : a;
        b_mag      = b[31] ? (32'd0 - b) : b;
        dvd        = div_signed ? a_mag : a;
        dvs        = div_signed ? b_mag : b;
        if (dvs == 32'd0) begin
            dvs = 32'd1;
        end
        quot_u = dvd / dvs;
        rem_u  = dvd % dvs;
        quot   = quot_u;
        rem    = rem_u;
        if (div_signed) begin
            if (a[31] ^ b[31]) begin
                quot = 32'd0 - quot_u;
            end
            if (a[31]) begin
                rem = 32'd0 - rem_u;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdop)
                        3'd0, 3'd1: begin
                            pend_hi_d = (mdop == 3'd0) ? prod_s[63:32] : prod_u[63:32];
                            pend_lo_d = (mdop == 3'd0) ? prod_s[31:0]  : prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_CYCLES - 1);
                            busy_d    = 1'b1;
                            state_d   = S_BUSY;
                        end
                        3'd2, 3'd3: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = 4'(DIV_CYCLES - 1);
                            busy_d    = 1'b1;
                            state_d   = S_BUSY;
                        end
                        3'd4:    hi_d = a;
                        3'd5:    lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'd7;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdop(mdop),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: what HI/LO hold once the operation has completed.
    function automatic void ref_apply(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                      inout logic [31:0] h, inout logic [31:0] l);
        longint sx, sy, ux, uy;
        logic [63:0] p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (op)
            3'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            3'd1: begin p = ux * uy; h = p[63:32]; l = p[31:0]; end
            3'd2: if (y != 32'd0) begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            3'd3: if (y != 32'd0) begin q = ux / uy; r = ux % uy; h = r[31:0]; l = q[31:0]; end
            3'd4: h = x;
            3'd5: l = x;
            default: ;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op);
        if (op <= 3'd1) return 5;
        if (op <= 3'd3) return 10;
        return 0;
    endfunction

    // Called 1ns after a rising edge: issues in that cycle, returns in the first cycle busy reads 0.
    task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int nbusy, output bit stable);
        logic [31:0] h0, l0;
        start = 1'b1; mdop = op; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd7;
        h0 = hi; l0 = lo; nbusy = 0; stable = 1'b1;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int nb; bit st;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 00000000", lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        do_op(3'd4, 32'h12345678, 32'd0, nb, st);
        ref_apply(3'd4, 32'h12345678, 32'd0, m_hi, m_lo);
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL mthi_busy got %0d busy cycles want 0", nb); end
    endtask

    task automatic test_mult();
        int nb; bit st;
        do_op(3'd0, 32'hFFFFFFFF, 32'd5, nb, st);
        ref_apply(3'd0, 32'hFFFFFFFF, 32'd5, m_hi, m_lo);
        n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL mult_busy got %0d want 5", nb); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL mult_hold got %b want 1", st); end
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFB) begin
            n_fail++; $display("FAIL mult_res got %h_%h want ffffffff_fffffffb", hi, lo); end
        do_op(3'd1, 32'hFFFFFFFF, 32'd5, nb, st);
        ref_apply(3'd1, 32'hFFFFFFFF, 32'd5, m_hi, m_lo);
        n_checks++; if (hi !== 32'h00000004 || lo !== 32'hFFFFFFFB) begin
            n_fail++; $display("FAIL multu_res got %h_%h want 00000004_fffffffb", hi, lo); end
    endtask

    task automatic test_div();
        int nb; bit st;
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, nb, st);
        ref_apply(3'd2, 32'hFFFFFFF9, 32'd2, m_hi, m_lo);
        n_checks++; if (nb !== 10) begin n_fail++; $display("FAIL div_busy got %0d want 10", nb); end
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_res got %h_%h want ffffffff_fffffffd", hi, lo); end
        do_op(3'd3, 32'd7, 32'd2, nb, st);
        ref_apply(3'd3, 32'd7, 32'd2, m_hi, m_lo);
        n_checks++; if (hi !== 32'd1 || lo !== 32'd3) begin
            n_fail++; $display("FAIL divu_res got %h_%h want 00000001_00000003", hi, lo); end
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, nb, st);
        ref_apply(3'd2, 32'h80000000, 32'hFFFFFFFF, m_hi, m_lo);
        n_checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
            n_fail++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
    endtask

    task automatic test_div_zero();
        int nb; bit st;
        do_op(3'd4, 32'hAAAA0000, 32'd0, nb, st);
        do_op(3'd5, 32'h0000BBBB, 32'd0, nb, st);
        do_op(3'd3, 32'd1234, 32'd0, nb, st);
        ref_apply(3'd4, 32'hAAAA0000, 32'd0, m_hi, m_lo);
        ref_apply(3'd5, 32'h0000BBBB, 32'd0, m_hi, m_lo);
        n_checks++; if (nb !== 10) begin n_fail++; $display("FAIL div0_busy got %0d want 10", nb); end
        n_checks++; if (hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) begin
            n_fail++; $display("FAIL div0_keep got %h_%h want aaaa0000_0000bbbb", hi, lo); end
    endtask

    task automatic test_ignored_start();
        int nb; bit st, lo_kept;
        logic [31:0] h0, l0;
        logic [31:0] rx, ry;
        h0 = hi; l0 = lo; nb = 0; lo_kept = 1'b1;
        start = 1'b1; mdop = 3'd0; a = 32'd3; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (busy === 1'b1) nb++;
            if (hi !== h0 || lo !== l0) lo_kept = 1'b0;
            start = (c == 2) || (c == 3);
            mdop  = (c == 2) ? 3'd5 : 3'd2;
            a     = (c == 2) ? 32'd1 : 32'd100;
            b     = 32'd3;
            @(posedge clk); #1;
        end
        start = 1'b0; mdop = 3'd7;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (hi !== h0 || lo !== l0) lo_kept = 1'b0;
            @(posedge clk); #1;
        end
        ref_apply(3'd0, 32'd3, 32'd7, m_hi, m_lo);
        n_checks++; if (nb !== 5) begin n_fail++; $display("FAIL ign_busy got %0d want 5", nb); end
        n_checks++; if (lo_kept !== 1'b1) begin n_fail++; $display("FAIL ign_hold got %b want 1", lo_kept); end
        n_checks++; if (hi !== 32'd0 || lo !== 32'd21) begin
            n_fail++; $display("FAIL ign_res got %h_%h want 00000000_00000015", hi, lo); end
        rx = $urandom; ry = $urandom;
        do_op(3'd1, rx, ry, nb, st);
        ref_apply(3'd1, rx, ry, m_hi, m_lo);
        n_checks++; if (nb !== 5 || hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL b2b_accept got busy %0d %h_%h want busy 5 %h_%h", nb, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        bit quiet;
        start = 1'b1; mdop = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; mdop = 3'd7;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL midrst got busy %b %h_%h want busy 0 00000000_00000000", busy, hi, lo); end
        quiet = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) quiet = 1'b0;
        end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL midrst_late got %b want 1", quiet); end
    endtask

    task automatic test_random();
        int nb; bit st;
        logic [2:0] op;
        logic [31:0] rx, ry;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            rx = $urandom;
            ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 9));
            do_op(op, rx, ry, nb, st);
            ref_apply(op, rx, ry, m_hi, m_lo);
            n_checks++; if (nb !== exp_busy(op) || st !== 1'b1) begin
                n_fail++; $display("FAIL rnd_busy op %0d got %0d hold %b want %0d hold 1", op, nb, st, exp_busy(op)); end
            n_checks++; if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL rnd_res op %0d a %h b %h got %h_%h want %h_%h", op, rx, ry, hi, lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
